// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and legal parameter ranges for the pipelined adder
package adder_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int STAGES_DEF = 2;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 128;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit combinational ripple slice with carry in and carry out
module adder_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready add/subtract pipeline, one W_S-bit carry slice per stage
module adder_pipe
  import adder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic              i_sub,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry,
  output logic              o_overflow
);
  localparam int W_S = DATA_W / STAGES;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || STAGES < STAGES_MIN ||
      STAGES > STAGES_MAX || (DATA_W % STAGES) != 0) begin : g_bad_param
    $error("adder_pipe: illegal DATA_W/STAGES combination");
  end

  logic w_en;
  assign w_en    = !o_valid || i_ready;
  assign o_ready = w_en;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W_S;
    logic [DATA_W-1:LO]   w_a;
    logic [DATA_W-1:LO]   w_b;
    logic [W_S-1:0]       w_slice;
    logic [LO+W_S-1:0]    w_s;
    logic                 w_cin;
    logic                 w_vin;
    logic                 w_cout;
    logic                 r_vld;
    logic                 r_c;
    logic [LO+W_S-1:0]    r_s;
    if (k == 0) begin : g_in
      assign w_a   = i_data_a;
      assign w_b   = i_sub ? ~i_data_b : i_data_b;
      assign w_cin = i_sub;
      assign w_vin = i_valid;
      assign w_s   = w_slice;
    end else begin : g_mid
      assign w_a   = g_st[k-1].g_fwd.r_a;
      assign w_b   = g_st[k-1].g_fwd.r_b;
      assign w_cin = g_st[k-1].r_c;
      assign w_vin = g_st[k-1].r_vld;
      assign w_s   = {w_slice, g_st[k-1].r_s};
    end
    adder_slice #(.W(W_S)) u_slice (
      .i_a   (w_a[LO +: W_S]),
      .i_b   (w_b[LO +: W_S]),
      .i_cin (w_cin),
      .o_sum (w_slice),
      .o_cout(w_cout)
    );
    // Data only loads on valid beats so bubbles leave outputs untouched after reset
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= '0;
      end else if (w_en) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_c <= w_cout;
          r_s <= w_s;
        end
      end
    end
    if (k < STAGES - 1) begin : g_fwd
      logic [DATA_W-1:LO+W_S] r_a;
      logic [DATA_W-1:LO+W_S] r_b;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en && w_vin) begin
          r_a <= w_a[DATA_W-1:LO+W_S];
          r_b <= w_b[DATA_W-1:LO+W_S];
        end
      end
    end else begin : g_last
      logic r_ovf;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_ovf <= 1'b0;
        else if (w_en && w_vin)
          r_ovf <= (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_slice[W_S-1] != w_a[DATA_W-1]);
      end
    end
  end

  assign o_valid    = g_st[STAGES-1].r_vld;
  assign o_sum      = g_st[STAGES-1].r_s;
  assign o_carry    = g_st[STAGES-1].r_c;
  assign o_overflow = g_st[STAGES-1].g_last.r_ovf;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed + random scoreboard bench for the 64-bit, 2-stage adder
module tb_adder_pipe;
  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vvalid;
  logic        rdy;
  logic        vsub;
  logic [63:0] va;
  logic [63:0] vb;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_sum;
  logic        o_carry;
  logic        o_ovf;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  adder_pipe #(.DATA_W(64), .STAGES(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (vvalid),
    .o_ready   (o_ready),
    .i_data_a  (va),
    .i_data_b  (vb),
    .i_sub     (vsub),
    .o_valid   (o_valid),
    .i_ready   (rdy),
    .o_sum     (o_sum),
    .o_carry   (o_carry),
    .o_overflow(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference built from wide signed/unsigned arithmetic rather than slices
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t              e;
    logic signed [65:0] f;
    logic [64:0]        u;
    f   = s ? $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b})
            : $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    u   = {1'b0, a} + {1'b0, b};
    e.s = s ? a - b : a + b;
    e.c = s ? (a >= b) : u[64];
    e.v = (f[65:63] != 3'b000) && (f[65:63] != 3'b111);
    return e;
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input exp_t e, input bit rnd);
    logic acc;
    acc    = 1'b0;
    va     = a;
    vb     = b;
    vsub   = s;
    vvalid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    vvalid = 1'b0;
    check("accepted", 64'(acc), 64'd1);
    if (acc) q.push_back(e);
  endtask

  logic        st_hold = 1'b0;
  logic [65:0] st_val;
  always @(negedge clk) begin
    if (rst) begin
      st_hold = 1'b0;
    end else begin
      if (st_hold) check("hold_stable", 64'({o_sum, o_carry, o_ovf}), 64'(st_val));
      if (st_hold) check("hold_sum", o_sum, st_val[65:2]);
      if (o_valid && rdy) begin
        check("q_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("sum", o_sum, e.s);
          check("carry", 64'(o_carry), 64'(e.c));
          check("overflow", 64'(o_ovf), 64'(e.v));
        end
      end
      st_hold = o_valid && !rdy;
      st_val  = {o_sum, o_carry, o_ovf};
    end
  end

  initial begin
    int idx;
    logic accd;
    rst    = 1'b1;
    vvalid = 1'b1;
    rdy    = 1'b1;
    vsub   = 1'b0;
    va     = 64'h1234_5678_9ABC_DEF0;
    vb     = 64'h0FED_CBA9_8765_4321;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_sum", o_sum, 64'd0);
    check("rst_carry", 64'(o_carry), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    vvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bubble_valid", 64'(o_valid), 64'd0);
      check("bubble_sum", o_sum, 64'd0);
    end
    @(posedge clk);
    #1;
    send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, exp_t'{s: 64'h0000_0001_0000_0000, c: 1'b0, v: 1'b0}, 1'b0);
    @(negedge clk);
    check("latency_1", 64'(o_valid), 64'd0);
    @(negedge clk);
    check("latency_2", 64'(o_valid), 64'd1);
    @(posedge clk);
    #1;
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, exp_t'{s: 64'h8000_0000_0000_0000, c: 1'b0, v: 1'b1}, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
         exp_t'{s: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b1, v: 1'b0}, 1'b0);
    send(64'd5, 64'd7, 1'b1, exp_t'{s: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b0, v: 1'b0}, 1'b0);
    send(64'd7, 64'd5, 1'b1, exp_t'{s: 64'd2, c: 1'b1, v: 1'b0}, 1'b0);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, exp_t'{s: 64'h7FFF_FFFF_FFFF_FFFF, c: 1'b1, v: 1'b1}, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    idx = 0;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      rdy = !(c >= 3 && c <= 5);
      vvalid = 1'b1;
      va     = 64'(idx);
      vb     = 64'd100;
      vsub   = 1'b0;
      @(negedge clk);
      if (c >= 3 && c <= 5) check("stall_ready", 64'(o_ready), 64'd0);
      accd = o_ready;
      @(posedge clk);
      #1;
      if (accd) begin
        q.push_back(exp_t'{s: 64'(100 + idx), c: 1'b0, v: 1'b0});
        idx++;
      end
    end
    vvalid = 1'b0;
    rdy    = 1'b1;
    check("bp_all_sent", 64'(idx), 64'd6);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      logic [63:0] a, b;
      logic s;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 6 == 0) b = a;
      s = 1'(($urandom_range(0, 1)));
      send(a, b, s, model(a, b, s), 1'b1);
    end
    rdy = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);
    send(64'd11, 64'd22, 1'b0, model(64'd11, 64'd22, 1'b0), 1'b0);
    send(64'd33, 64'd44, 1'b0, model(64'd33, 64'd44, 1'b0), 1'b0);
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_sum", o_sum, 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(o_valid), 64'd0);
    end
    send(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0,
         model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0), 1'b0);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("final_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
